fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_ctrl.sv | 101 ++++++++++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared LC-3b pipeline types used by the fetch stage: FSM encoding and NOP word.
// Optional skid buffer is selected with `define FETCH_SKID_EN.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        SKID
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_STEP   = 16'd2;

    // Instructions are halfword aligned; bit 0 of any target is discarded.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_stage_ctrl.sv
// Fetch FSM: sequences the icache handshake and produces PC / IF-ID / skid load enables.
// Skid handling (SKID state) is present only when FETCH_SKID_EN is defined.
module fetch_ctrl
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic icache_resp,
    input  logic stall,
    input  logic redirect,
    output logic icache_read,
    output logic drain_sel,
    output logic drain_addr_load,
    output logic pc_inc,
    output logic pc_redirect,
    output logic ifid_word,
    output logic ifid_bubble
`ifdef FETCH_SKID_EN
    ,
    output logic skid_load,
    output logic pc_from_skid,
    output logic ifid_skid
`endif
);

    fetch_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next      = state;
        icache_read     = 1'b0;
        drain_sel       = 1'b0;
        drain_addr_load = 1'b0;
        pc_inc          = 1'b0;
        pc_redirect     = 1'b0;
        ifid_word       = 1'b0;
        ifid_bubble     = 1'b0;
`ifdef FETCH_SKID_EN
        skid_load       = 1'b0;
        pc_from_skid    = 1'b0;
        ifid_skid       = 1'b0;
`endif
        case (state)
            IDLE: begin
                pc_redirect = redirect;
                state_next  = FETCH;
            end
            FETCH: begin
                icache_read = 1'b1;
                if (redirect) begin
                    pc_redirect = 1'b1;
                    ifid_bubble = !stall;
                    // Request stays outstanding: remember its address and wait it out.
                    if (!icache_resp) begin
                        drain_addr_load = 1'b1;
                        state_next      = DRAIN;
                    end
                end else if (icache_resp) begin
                    if (!stall) begin
                        ifid_word = 1'b1;
                        pc_inc    = 1'b1;
                    end
`ifdef FETCH_SKID_EN
                    else begin
                        skid_load  = 1'b1;
                        state_next = SKID;
                    end
`endif
                end else begin
                    ifid_bubble = !stall;
                end
            end
            DRAIN: begin
                icache_read = 1'b1;
                drain_sel   = 1'b1;
                pc_redirect = redirect;
                ifid_bubble = !stall;
                if (icache_resp) state_next = FETCH;
            end
`ifdef FETCH_SKID_EN
            SKID: begin
                if (redirect) begin
                    pc_redirect = 1'b1;
                    ifid_bubble = !stall;
                    state_next  = FETCH;
                end else if (!stall) begin
                    ifid_skid    = 1'b1;
                    pc_from_skid = 1'b1;
                    state_next   = FETCH;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: PC, icache request, IF/ID pipeline register.
// `define FETCH_SKID_EN adds a one-entry skid buffer for words returned during stall.
module fetch_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        icache_read,
    output logic [15:0] icache_address,
    input  logic        icache_resp,
    input  logic [15:0] icache_rdata,
    input  logic        stall,
    input  logic        squash_ID,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] IF_ID_ir,
    output logic [15:0] IF_ID_pc,
    output logic        IF_ID_valid
);

    logic [15:0] pc, drain_addr, ir_q, ifpc_q;
    logic        valid_q;
    logic        drain_sel, drain_addr_load, pc_inc, pc_redirect, ifid_word, ifid_bubble;
`ifdef FETCH_SKID_EN
    logic [15:0] skid_ir, skid_pc;
    logic        skid_load, pc_from_skid, ifid_skid;
`endif

    fetch_ctrl u_ctrl (
        .clk             (clk),
        .reset_n         (reset_n),
        .icache_resp     (icache_resp),
        .stall           (stall),
        .redirect        (redirect),
        .icache_read     (icache_read),
        .drain_sel       (drain_sel),
        .drain_addr_load (drain_addr_load),
        .pc_inc          (pc_inc),
        .pc_redirect     (pc_redirect),
        .ifid_word       (ifid_word),
        .ifid_bubble     (ifid_bubble)
`ifdef FETCH_SKID_EN
        ,
        .skid_load       (skid_load),
        .pc_from_skid    (pc_from_skid),
        .ifid_skid       (ifid_skid)
`endif
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            ir_q       <= NOP_INSTR;
            ifpc_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (pc_redirect)  pc <= align_pc(redirect_pc);
            else if (pc_inc)  pc <= pc + PC_STEP;
`ifdef FETCH_SKID_EN
            else if (pc_from_skid) pc <= skid_pc + PC_STEP;
`endif
            if (drain_addr_load) drain_addr <= pc;

            if (ifid_word) begin
                ir_q    <= icache_rdata;
                ifpc_q  <= pc + PC_STEP;
                valid_q <= 1'b1;
            end else if (ifid_bubble) begin
                ir_q    <= NOP_INSTR;
                ifpc_q  <= '0;
                valid_q <= 1'b0;
            end
`ifdef FETCH_SKID_EN
            else if (ifid_skid) begin
                ir_q    <= skid_ir;
                ifpc_q  <= skid_pc + PC_STEP;
                valid_q <= 1'b1;
            end
`endif
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_ir <= NOP_INSTR;
            skid_pc <= '0;
        end else if (skid_load) begin
            skid_ir <= icache_rdata;
            skid_pc <= pc;
        end
    end
`endif

    // After a redirect the PC already holds the target while the old request drains.
    assign icache_address = drain_sel ? drain_addr : pc;
    assign IF_ID_ir       = squash_ID ? NOP_INSTR : ir_q;
    assign IF_ID_pc       = ifpc_q;
    assign IF_ID_valid    = valid_q & ~squash_ID;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table for the main flow plus hand sequences
// for stall/skid, redirect-drain and reset-during-drain.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        icache_read;
    logic [15:0] icache_address;
    logic        icache_resp;
    logic [15:0] icache_rdata;
    logic        stall;
    logic        squash_ID;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] IF_ID_ir;
    logic [15:0] IF_ID_pc;
    logic        IF_ID_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h3000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .stall          (stall),
        .squash_ID      (squash_ID),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .IF_ID_ir       (IF_ID_ir),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_valid    (IF_ID_valid)
    );

    typedef struct {
        logic        stall;
        logic        squash;
        logic        redir;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
        logic        e_read;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
        logic        e_valid;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_read, input logic [15:0] e_addr,
                           input logic [15:0] e_ir, input logic [15:0] e_pc, input logic e_valid);
        chk({tag, ".read"},  {15'd0, icache_read}, {15'd0, e_read});
        chk({tag, ".addr"},  icache_address, e_addr);
        chk({tag, ".ir"},    IF_ID_ir, e_ir);
        chk({tag, ".pc"},    IF_ID_pc, e_pc);
        chk({tag, ".valid"}, {15'd0, IF_ID_valid}, {15'd0, e_valid});
    endtask

    // Apply one cycle of inputs mid-cycle; outputs are sampled 1ns later, well before posedge.
    task automatic drive(input logic rst, input logic st, input logic sq, input logic rd,
                         input logic [15:0] rpc, input logic rsp, input logic [15:0] rdat);
        @(negedge clk);
        reset_n      = rst;
        stall        = st;
        squash_ID    = sq;
        redirect     = rd;
        redirect_pc  = rpc;
        icache_resp  = rsp;
        icache_rdata = rdat;
        #1;
    endtask

    initial begin
        //            stall sq  rd  rpc       resp rdata      read addr      ir        pc        valid
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 16'h3000, 16'h0000, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'h3002, 16'h1111, 16'h3002, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 16'h3004, 16'h2222, 16'h3004, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3006, 16'h3333, 16'h3006, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0E05, 1'b1, 16'h3006, 16'h0000, 16'h0000, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3008, 16'h0E05, 16'h3008, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3008, 16'h0000, 16'h3008, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 1'b1, 16'h3008, 16'h0E05, 16'h3008, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 16'h300A, 16'h4444, 16'h300A, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h6666, 16'h0000, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 16'h3000, 1'b1, 16'h7777, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3000, 16'h0000, 16'h0000, 1'b0};

        // Reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk_all("reset", 1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b0);

        // Main flow: zero-wait fetch, bubble, stall hold, squash, redirect, wrap
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, tbl[i].stall, tbl[i].squash, tbl[i].redir, tbl[i].rpc,
                  tbl[i].resp, tbl[i].rdata);
            chk_all($sformatf("row%0d", i), tbl[i].e_read, tbl[i].e_addr,
                    tbl[i].e_ir, tbl[i].e_pc, tbl[i].e_valid);
        end

        // Stall while the word for 3002 returns
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0AAA);
        chk("stl.addr0", icache_address, 16'h3000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1261);
        chk("stl.addr1", icache_address, 16'h3002);
        chk("stl.ir1", IF_ID_ir, 16'h0AAA);
`ifdef FETCH_SKID_EN
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("skid.read2", {15'd0, icache_read}, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("skid.read3", {15'd0, icache_read}, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("skid.read4", {15'd0, icache_read}, 16'h0000);
        chk("skid.ir4", IF_ID_ir, 16'h0AAA);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
`else
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("drop.addr2", icache_address, 16'h3002);
        chk("drop.ir2", IF_ID_ir, 16'h0AAA);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1261);
        chk("drop.refetch", icache_address, 16'h3002);
        chk("drop.read", {15'd0, icache_read}, 16'h0001);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
`endif
        chk_all("stl.out", 1'b1, 16'h3004, 16'h1261, 16'h3004, 1'b1);

        // Redirect to 4000 with 3004 outstanding; response two cycles later
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h0);
        chk("rd.addr0", icache_address, 16'h3004);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk_all("rd.c1", 1'b1, 16'h3004, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0BAD);
        chk_all("rd.c2", 1'b1, 16'h3004, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk_all("rd.c3", 1'b1, 16'h4000, 16'h0000, 16'h0000, 1'b0);

        // Second redirect while draining replaces the pending target
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5101, 1'b0, 16'h0);
        chk("dr2.addr", icache_address, 16'h4000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0BAD);
        chk("dr2.addr_resp", icache_address, 16'h4000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk_all("dr2.tgt", 1'b1, 16'h5100, 16'h0000, 16'h0000, 1'b0);

        // Reset while draining; the late response must be ignored
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h6000, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("rst.pre_addr", icache_address, 16'h5100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0BAD);
        chk_all("rst.idle", 1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk_all("rst.fetch", 1'b1, 16'h3000, 16'h0000, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
